clasificador_vc: RTL and testbench

- Ingress classifier that sits directly upstream of the VC0/VC1 FIFOs. Those FIFOs feed the routing arbiter.
- Accepts one 6-bit word per cycle through a valid/ready handshake and selects the target VC from a class bit.
- Pushes the word into the VC0 or VC1 FIFO, respecting the full and almost-full flags of each FIFO.
- Preserves global arrival order with a 2-entry holding buffer and keeps a wrapping push counter per VC.

---
 rtl/clasificador_vc_pkg.sv | 26 ++
 rtl/clasificador_vc_buffer_skid.sv | 98 +++++++++
 rtl/clasificador_vc.sv | 118 +++++++++++
 tb/tb_clasificador_vc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clasificador_vc_pkg.sv
// -----------------------------------------------------------------------------
// clasificador_vc_pkg
// Shared definitions for the VC ingress classifier:
//   - default word width, class-bit index and push-counter width
//   - holding-buffer state encoding (EMPTY / ONE / TWO)
//   - helper that extracts the target VC from a word
// -----------------------------------------------------------------------------
package clasificador_vc_pkg;

  localparam int DATA_W_DEF    = 6;
  localparam int CLASS_BIT_DEF = 5;
  localparam int CNT_W_DEF     = 8;

  // Occupancy of the main/skid holding buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Target VC of a word: 0 selects VC0, 1 selects VC1.
  function automatic logic vc_sel(input logic [DATA_W_DEF-1:0] w);
    return w[CLASS_BIT_DEF];
  endfunction

endpackage

// File: rtl/clasificador_vc_buffer_skid.sv
// -----------------------------------------------------------------------------
// clasificador_vc_buffer_skid
// Two-entry in-order holding buffer. "main" holds the oldest word, "skid" the
// second one. The head (main) leaves when issue_i is high; a new word enters
// when in_valid_i && in_ready_o.
//
// Handshake: a word transfers at a rising edge where in_valid_i and in_ready_o
// are both 1. in_ready_o is combinational from reset and state only (it never
// depends on in_valid_i), so the upstream may hold data stable until accepted.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_data_i      incoming word
//   in_valid_i     incoming word valid
//   in_ready_o     buffer can take a word this cycle
//   issue_i        head word is consumed at this edge (ignored when empty)
//   head_data_o    oldest buffered word
//   head_valid_o   buffer is not empty
//   state_o        debug view of the occupancy state
// -----------------------------------------------------------------------------
module clasificador_vc_buffer_skid
  import clasificador_vc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              issue_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_valid_o,
  output logic [1:0]        state_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid_i && in_ready_o;
    unique case (state_q)
      EMPTY: begin
        // Nothing to issue from EMPTY, whatever issue_i says.
        if (accept) begin
          main_d  = in_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (issue_i && accept) begin
          main_d = in_data_i;
        end else if (issue_i) begin
          state_d = EMPTY;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = TWO;
        end
      end
      TWO: begin
        // No accept possible here: in_ready_o is low.
        if (issue_i) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready_o   = !reset && (state_q != TWO);
    head_valid_o = (state_q != EMPTY);
    head_data_o  = main_q;
    state_o      = state_q;
  end

endmodule

// File: rtl/clasificador_vc.sv
// -----------------------------------------------------------------------------
// clasificador_vc
// Ingress classifier feeding the VC0/VC1 FIFOs. Words are held in a 2-entry
// in-order buffer; the oldest word is pushed to the FIFO selected by its class
// bit whenever that FIFO is neither full nor almost full. Order is strict
// across both VCs (a blocked head stalls everything behind it).
//
// Handshake: a word on data_in is taken at a rising edge where valid_in and
// ready_in are both 1; ready_in = !reset && (state != TWO).
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   data_in, valid_in, ready_in       ingress valid/ready interface
//   VC0_full, VC1_full                FIFO full flags
//   VC0_almost_full, VC1_almost_full  FIFO has at most one free slot
//   VC0_push, VC1_push                registered push strobes
//   VC0_data, VC1_data                registered push data (held when idle)
//   count_VC0, count_VC1              wrapping per-VC push counters
//   state_dbg                         buffer state (0 EMPTY, 1 ONE, 2 TWO)
// -----------------------------------------------------------------------------
module clasificador_vc
  import clasificador_vc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CLASS_BIT = CLASS_BIT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              VC0_full,
  input  logic              VC1_full,
  input  logic              VC0_almost_full,
  input  logic              VC1_almost_full,
  output logic              VC0_push,
  output logic              VC1_push,
  output logic [DATA_W-1:0] VC0_data,
  output logic [DATA_W-1:0] VC1_data,
  output logic [CNT_W-1:0]  count_VC0,
  output logic [CNT_W-1:0]  count_VC1,
  output logic [1:0]        state_dbg
);

  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              tgt;
  logic              blocked0, blocked1;
  logic              issue;

  logic              vc0_push_q, vc0_push_d;
  logic              vc1_push_q, vc1_push_d;
  logic [DATA_W-1:0] vc0_data_q, vc0_data_d;
  logic [DATA_W-1:0] vc1_data_q, vc1_data_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  clasificador_vc_buffer_skid #(
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .in_data_i    (data_in),
    .in_valid_i   (valid_in),
    .in_ready_o   (ready_in),
    .issue_i      (issue),
    .head_data_o  (head_data),
    .head_valid_o (head_valid),
    .state_o      (state_dbg)
  );

  // Almost-full counts as blocked: the push is registered, so the flag seen
  // now lags the FIFO by one cycle and we need that one-slot margin.
  always_comb begin
    tgt      = head_data[CLASS_BIT];
    blocked0 = VC0_full || VC0_almost_full;
    blocked1 = VC1_full || VC1_almost_full;
    issue    = head_valid && !(tgt ? blocked1 : blocked0);
  end

  always_comb begin
    vc0_push_d = issue && !tgt;
    vc1_push_d = issue && tgt;
    vc0_data_d = vc0_push_d ? head_data : vc0_data_q;
    vc1_data_d = vc1_push_d ? head_data : vc1_data_q;
    cnt0_d     = cnt0_q + CNT_W'(vc0_push_d);
    cnt1_d     = cnt1_q + CNT_W'(vc1_push_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vc0_push_q <= 1'b0;
      vc1_push_q <= 1'b0;
      vc0_data_q <= '0;
      vc1_data_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      vc0_push_q <= vc0_push_d;
      vc1_push_q <= vc1_push_d;
      vc0_data_q <= vc0_data_d;
      vc1_data_q <= vc1_data_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  always_comb begin
    VC0_push  = vc0_push_q;
    VC1_push  = vc1_push_q;
    VC0_data  = vc0_data_q;
    VC1_data  = vc1_data_q;
    count_VC0 = cnt0_q;
    count_VC1 = cnt1_q;
  end

endmodule

// File: tb/tb_clasificador_vc.sv
// -----------------------------------------------------------------------------
// tb_clasificador_vc
// Directed bench for clasificador_vc. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_clasificador_vc;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic              VC0_full, VC1_full;
  logic              VC0_almost_full, VC1_almost_full;
  logic              VC0_push, VC1_push;
  logic [DATA_W-1:0] VC0_data, VC1_data;
  logic [CNT_W-1:0]  count_VC0, count_VC1;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clasificador_vc dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .VC0_full        (VC0_full),
    .VC1_full        (VC1_full),
    .VC0_almost_full (VC0_almost_full),
    .VC1_almost_full (VC1_almost_full),
    .VC0_push        (VC0_push),
    .VC1_push        (VC1_push),
    .VC0_data        (VC0_data),
    .VC1_data        (VC1_data),
    .count_VC0       (count_VC0),
    .count_VC1       (count_VC1),
    .state_dbg       (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_push(input string tag, input logic p0, input logic [5:0] d0,
                            input logic p1, input logic [5:0] d1);
    check({tag, "_p0"}, 32'(VC0_push), 32'(p0));
    check({tag, "_p1"}, 32'(VC1_push), 32'(p1));
    if (p0) check({tag, "_d0"}, 32'(VC0_data), 32'(d0));
    if (p1) check({tag, "_d1"}, 32'(VC1_data), 32'(d1));
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b1; data_in = 6'h2A;
    VC0_full = 1'b0; VC1_full = 1'b0;
    VC0_almost_full = 1'b0; VC1_almost_full = 1'b0;

    // Reset held for 3 cycles with valid input present.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(ready_in), 32'd0);
      check_push("rst_push", 1'b0, 6'h00, 1'b0, 6'h00);
      check("rst_cnt0", 32'(count_VC0), 32'd0);
      check("rst_cnt1", 32'(count_VC1), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(S_EMPTY));
    end
    reset = 1'b0; valid_in = 1'b0;
    #1;
    check("rel_ready", 32'(ready_in), 32'd1);

    // Streaming 01,21,02,22: each pushed one edge after acceptance.
    tick();
    valid_in = 1'b1; data_in = 6'h01; tick();
    check("str0_state", 32'(state_dbg), 32'(S_ONE));
    check_push("str0", 1'b0, 6'h00, 1'b0, 6'h00);
    data_in = 6'h21; tick();
    check_push("str1", 1'b1, 6'h01, 1'b0, 6'h00);
    data_in = 6'h02; tick();
    check_push("str2", 1'b0, 6'h00, 1'b1, 6'h21);
    data_in = 6'h22; tick();
    check_push("str3", 1'b1, 6'h02, 1'b0, 6'h00);
    valid_in = 1'b0; tick();
    check_push("str4", 1'b0, 6'h00, 1'b1, 6'h22);
    check("str_cnt0", 32'(count_VC0), 32'd2);
    check("str_cnt1", 32'(count_VC1), 32'd2);
    tick();
    check_push("str5", 1'b0, 6'h00, 1'b0, 6'h00);
    check("str_state", 32'(state_dbg), 32'(S_EMPTY));
    check("str_hold_d0", 32'(VC0_data), 32'h02);

    // Backpressure with head-of-line blocking.
    VC0_almost_full = 1'b1;
    valid_in = 1'b1; data_in = 6'h05; tick();
    check("bp0_state", 32'(state_dbg), 32'(S_ONE));
    data_in = 6'h25; tick();
    check("bp1_state", 32'(state_dbg), 32'(S_TWO));
    check("bp1_ready", 32'(ready_in), 32'd0);
    check_push("bp1", 1'b0, 6'h00, 1'b0, 6'h00);
    data_in = 6'h26; tick();
    check("bp2_state", 32'(state_dbg), 32'(S_TWO));
    check_push("bp2", 1'b0, 6'h00, 1'b0, 6'h00);
    check("bp2_cnt1", 32'(count_VC1), 32'd2);
    VC0_almost_full = 1'b0; tick();
    check_push("bp3", 1'b1, 6'h05, 1'b0, 6'h00);
    check("bp3_state", 32'(state_dbg), 32'(S_ONE));
    tick();
    check_push("bp4", 1'b0, 6'h00, 1'b1, 6'h25);
    check("bp4_state", 32'(state_dbg), 32'(S_ONE));
    valid_in = 1'b0; tick();
    check_push("bp5", 1'b0, 6'h00, 1'b1, 6'h26);
    check("bp5_state", 32'(state_dbg), 32'(S_EMPTY));
    check("bp_cnt0", 32'(count_VC0), 32'd3);
    check("bp_cnt1", 32'(count_VC1), 32'd4);

    // Simultaneous issue and accept in ONE.
    valid_in = 1'b1; data_in = 6'h11; tick();
    check("sim0_state", 32'(state_dbg), 32'(S_ONE));
    data_in = 6'h30; tick();
    check_push("sim1", 1'b1, 6'h11, 1'b0, 6'h00);
    check("sim1_state", 32'(state_dbg), 32'(S_ONE));
    valid_in = 1'b0; tick();
    check_push("sim2", 1'b0, 6'h00, 1'b1, 6'h30);
    check("sim_cnt0", 32'(count_VC0), 32'd4);
    check("sim_cnt1", 32'(count_VC1), 32'd5);

    // Counter wrap: 256 back-to-back pushes to VC1 from a cleared counter.
    reset = 1'b1; tick();
    reset = 1'b0;
    check("wrap_clr1", 32'(count_VC1), 32'd0);
    for (int i = 0; i <= 256; i++) begin
      valid_in = (i < 256);
      data_in  = 6'h20 | 6'(i % 32);
      tick();
      if (i >= 1) begin
        check("wrap_push", 32'(VC1_push), 32'd1);
        check("wrap_data", 32'(VC1_data), 32'(6'h20 | 6'((i - 1) % 32)));
        check("wrap_cnt", 32'(count_VC1), 32'(i % 256));
      end
      if (i == 255) check("wrap_255", 32'(count_VC1), 32'd255);
    end
    check("wrap_0", 32'(count_VC1), 32'd0);
    check("wrap_cnt0", 32'(count_VC0), 32'd0);
    check("wrap_state", 32'(state_dbg), 32'(S_EMPTY));

    // Reset while in TWO: buffered words are dropped.
    VC1_full = 1'b1;
    valid_in = 1'b1; data_in = 6'h21; tick();
    data_in = 6'h22; tick();
    check("mr_state_two", 32'(state_dbg), 32'(S_TWO));
    check_push("mr_pre", 1'b0, 6'h00, 1'b0, 6'h00);
    reset = 1'b1; VC1_full = 1'b0; data_in = 6'h3F; tick();
    check_push("mr_edge", 1'b0, 6'h00, 1'b0, 6'h00);
    check("mr_ready", 32'(ready_in), 32'd0);
    check("mr_state", 32'(state_dbg), 32'(S_EMPTY));
    check("mr_cnt0", 32'(count_VC0), 32'd0);
    check("mr_cnt1", 32'(count_VC1), 32'd0);
    reset = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_push("mr_after", 1'b0, 6'h00, 1'b0, 6'h00);
      check("mr_after_cnt1", 32'(count_VC1), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
